// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed N-digit seven-segment driver. Scans one digit
//               per refresh slot, decodes hex nibbles to active-low segments
//               {a,b,c,d,e,f,g,dp}, and double-buffers display data so new
//               values appear only at frame boundaries.
//               Optional macro SEG_SCAN_LEADING_ZERO_BLANK_EN enables
//               leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] C_PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] C_IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [PW-1:0] C_GUARD      = PW'(GUARD);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]     pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [7:0]              seg_q, seg_d;
  logic [N_DIGITS-1:0]     an_q, an_d;

  logic                    w_tick, w_wrap;
  logic [3:0]              w_nib;
  logic                    w_dp, w_blank, w_sup;
  logic [N_DIGITS-1:0]     w_sel_n;
  logic [N_DIGITS-1:0]     w_sup_vec;

  // Hex nibble to active-low {a,b,c,d,e,f,g}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001101;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  assign w_tick = (presc_q == C_PRESC_LAST);
  // Wrap happens only while scanning; this is also the frame pulse.
  assign w_wrap = en && w_tick && (idx_q == C_IDX_LAST);
  assign frame  = w_wrap;
  assign seg    = seg_q;
  assign an     = an_q;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  // w_lz_above[i]: every digit more significant than i is zero or blanked.
  logic [N_DIGITS-1:0] w_lz_above;
  assign w_lz_above[N_DIGITS-1] = 1'b1;
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_lz
    if (g < N_DIGITS - 1) begin : g_chain
      assign w_lz_above[g] = w_lz_above[g+1] &
                             ((act_data_q[4*(g+1) +: 4] == 4'h0) | act_blank_q[g+1]);
    end
    assign w_sup_vec[g] = (g != 0) && (act_data_q[4*g +: 4] == 4'h0) && w_lz_above[g];
  end
`else
  assign w_sup_vec = '0;
`endif

  // Select the active data of the digit currently being scanned
  always_comb begin
    w_nib   = 4'h0;
    w_dp    = 1'b0;
    w_blank = 1'b1;
    w_sup   = 1'b0;
    w_sel_n = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        w_nib      = act_data_q[4*i +: 4];
        w_dp       = act_dp_q[i];
        w_blank    = act_blank_q[i];
        w_sup      = w_sup_vec[i];
        w_sel_n[i] = 1'b0;
      end
    end
  end

  // Prescaler and digit index; EN low holds the scan at digit 0, count 0
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (!en) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (w_tick) begin
      presc_d = '0;
      idx_d   = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Double buffer: LOAD fills pending, wrap promotes it; LOAD on wrap bypasses
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_flag_d  = pend_flag_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    if (load) begin
      pend_data_d  = data;
      pend_dp_d    = dp;
      pend_blank_d = blank;
      pend_flag_d  = 1'b1;
    end
    if (w_wrap) begin
      if (load) begin
        act_data_d  = data;
        act_dp_d    = dp;
        act_blank_d = blank;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        act_data_d  = pend_data_q;
        act_dp_d    = pend_dp_q;
        act_blank_d = pend_blank_q;
        pend_flag_d = 1'b0;
      end
    end
  end

  // Next segment/anode pattern; dark during guard, blank, or disabled scan
  always_comb begin
    seg_d = 8'hFF;
    an_d  = '1;
    if (en && (presc_q >= C_GUARD) && !w_blank) begin
      if (!w_sup) begin
        seg_d = {hex7(w_nib), ~w_dp};
        an_d  = w_sel_n;
      end else if (w_dp) begin
        // Suppressed zero keeps its decimal point visible
        seg_d = 8'hFE;
        an_d  = w_sel_n;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      pend_flag_q  <= 1'b0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      seg_q        <= 8'hFF;
      an_q         <= '1;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_flag_q  <= pend_flag_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Self-checking bench for seg_scan_driver (4 digits, 4-cycle
//               slots, 1-cycle guard) with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int GRD = 1;
  localparam int FR  = N * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame;

  int errors = 0;
  int checks = 0;

  seg_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV), .GUARD(GRD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data),
    .dp(dp), .blank(blank), .seg(seg), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  // Segment table {a..g}, active low
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[n];
  endfunction

  // Reference model: m_t is the position (0..FR-1) within the scan frame
  int          m_t;
  logic [15:0] m_act_data, m_pend_data;
  logic [3:0]  m_act_dp, m_act_blank, m_pend_dp, m_pend_blank;
  logic        m_pflag;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;

  always @(posedge clk or negedge rst_n) begin : p_model
    int d, pos;
    logic [3:0] nib;
    logic sup, wrap;
    if (!rst_n) begin
      m_t = 0;
      m_act_data = 16'h0; m_act_dp = 4'h0; m_act_blank = 4'hF;
      m_pend_data = 16'h0; m_pend_dp = 4'h0; m_pend_blank = 4'hF;
      m_pflag = 1'b0;
      exp_seg = 8'hFF;
      exp_an = 4'hF;
    end else begin
      d   = m_t / DIV;
      pos = m_t % DIV;
      nib = m_act_data[4*d +: 4];
      exp_seg = 8'hFF;
      exp_an  = 4'hF;
      if (en && pos >= GRD && !m_act_blank[d]) begin
        sup = 1'b0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        if (d > 0 && nib == 4'h0) begin
          sup = 1'b1;
          for (int j = d + 1; j < N; j++)
            if (m_act_data[4*j +: 4] != 4'h0 && !m_act_blank[j]) sup = 1'b0;
        end
`endif
        if (!sup) begin
          exp_seg = {seg7(nib), ~m_act_dp[d]};
          exp_an  = ~(4'b0001 << d);
        end else if (m_act_dp[d]) begin
          exp_seg = 8'hFE;
          exp_an  = ~(4'b0001 << d);
        end
      end
      wrap = en && (m_t == FR - 1);
      if (wrap && load) begin
        m_act_data = data; m_act_dp = dp; m_act_blank = blank;
        m_pflag = 1'b0;
      end else begin
        if (wrap && m_pflag) begin
          m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
          m_pflag = 1'b0;
        end
        if (load) begin
          m_pend_data = data; m_pend_dp = dp; m_pend_blank = blank;
          m_pflag = 1'b1;
        end
      end
      m_t = en ? (m_t + 1) % FR : 0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin : p_compare
    logic exp_frame;
    exp_frame = rst_n && en && (m_t == FR - 1);
    checks++;
    if (seg !== exp_seg || an !== exp_an || frame !== exp_frame) begin
      errors++;
      $display("FAIL model_cycle t=%0t: seg=%b an=%b frame=%b, expected seg=%b an=%b frame=%b",
               $time, seg, an, frame, exp_seg, exp_an, exp_frame);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    load = 1'b1; data = d; dp = p; blank = b;
    step(1);
    load = 1'b0;
  endtask

  // Returns at the negedge of the cycle in which FRAME is high
  task automatic wait_frame(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * FR && !seen; i++) begin
      @(negedge clk);
      if (frame === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no frame pulse within %0d cycles", name, 3 * FR);
    end
  endtask

  logic [7:0] cap_seg [FR];
  logic [3:0] cap_an  [FR];

  // Capture the 16 cycles following a frame pulse (k=2..4 digit0, 6..8 digit1, ...)
  task automatic capture();
    for (int k = 0; k < FR; k++) begin
      @(negedge clk);
      cap_seg[k] = seg;
      cap_an[k]  = an;
    end
  endtask

  initial begin : p_stim
    int nfr, bad, cnt;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_seg", seg, 8'hFF);
    chk("reset_an", an, 4'hF);
    chk("reset_frame", frame, 1'b0);

    // Idle scan with reset (all-blank) buffers
    @(posedge clk); #2;
    rst_n = 1'b1; en = 1'b1;
    nfr = 0; bad = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      @(negedge clk);
      if (frame === 1'b1) nfr++;
      if (an !== 4'hF || seg !== 8'hFF) bad++;
    end
    chk("idle_frame_count", nfr, 2);
    chk("idle_dark", bad, 0);

    // Mid-frame load stays hidden until the next frame
    step(5);
    do_load(16'h12AF, 4'h0, 4'h0);
    @(negedge clk);
    chk("old_data_until_frame", an, 4'hF);
    wait_frame("frame_after_load");
    capture();
    chk("guard_an", cap_an[1], 4'hF);
    chk("d0_an", cap_an[3], 4'b1110);
    chk("d0_seg_F", cap_seg[3], 8'b01110001);
    chk("d1_an", cap_an[7], 4'b1101);
    chk("d1_seg_A", cap_seg[7], 8'b00010001);
    chk("d2_an", cap_an[11], 4'b1011);
    chk("d2_seg_2", cap_seg[11], 8'b00100101);
    chk("d3_an", cap_an[15], 4'b0111);
    chk("d3_seg_1", cap_seg[15], 8'b10011111);

    // Two loads before a wrap: last one wins
    step(3);
    do_load(16'h1111, 4'h0, 4'h0);
    step(2);
    do_load(16'h2222, 4'h0, 4'h0);
    wait_frame("frame_after_two_loads");
    capture();
    chk("last_load_wins_d0", cap_seg[3], 8'b00100101);
    chk("last_load_wins_d3", cap_seg[15], 8'b00100101);

    // Load coincident with the wrap tick goes straight to the active buffer
    repeat (FR) @(posedge clk);
    #2;
    load = 1'b1; data = 16'h3456; dp = 4'h0; blank = 4'h0;
    @(negedge clk);
    chk("coincident_frame", frame, 1'b1);
    @(posedge clk); #2;
    load = 1'b0;
    capture();
    chk("coincident_d0_6", cap_seg[3], 8'b01000001);
    chk("coincident_d1_5", cap_seg[7], 8'b01001001);
    chk("coincident_d3_3", cap_seg[15], 8'b00001101);

    // Decimal point and blank mask
    do_load(16'h89AB, 4'b0100, 4'b0010);
    wait_frame("frame_dp_blank");
    capture();
    chk("dp_d2_seg", cap_seg[11], 8'b00001000);
    chk("dp_d2_an", cap_an[11], 4'b1011);
    chk("blank_d1_an", cap_an[7], 4'hF);
    chk("blank_d1_seg", cap_seg[7], 8'hFF);
    chk("dp_off_d0_B", cap_seg[3], 8'b11000001);

    // EN dropped mid-frame for 5 cycles
    step(6);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("en_low_seg", seg, 8'hFF);
    chk("en_low_an", an, 4'hF);
    chk("en_low_frame", frame, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      @(negedge clk);
      cnt++;
      if (frame === 1'b1) break;
    end
    chk("restart_frame_gap", cnt, FR);

    // Asynchronous reset mid-slot; pending data is lost
    step(1);
    do_load(16'h5555, 4'h0, 4'h0);
    step(3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_seg", seg, 8'hFF);
    chk("async_rst_an", an, 4'hF);
    chk("async_rst_frame", frame, 1'b0);
    step(2);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 2 * FR + 4; i++) begin
      @(negedge clk);
      if (an !== 4'hF) bad++;
    end
    chk("post_reset_dark", bad, 0);

    // Leading-zero case
    do_load(16'h0050, 4'b1000, 4'b0000);
    wait_frame("frame_lz");
    capture();
    chk("lz_d0_zero", cap_seg[3], 8'b00000011);
    chk("lz_d1_five", cap_seg[7], 8'b01001001);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    chk("lz_d2_an", cap_an[11], 4'hF);
    chk("lz_d2_seg", cap_seg[11], 8'hFF);
    chk("lz_d3_an", cap_an[15], 4'b0111);
    chk("lz_d3_seg", cap_seg[15], 8'hFE);
`else
    chk("lz_d2_an", cap_an[11], 4'b1011);
    chk("lz_d2_seg", cap_seg[11], 8'b00000011);
    chk("lz_d3_an", cap_an[15], 4'b0111);
    chk("lz_d3_seg", cap_seg[15], 8'b00000010);
`endif

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed N-digit seven-segment display driver.
- Scans one digit per refresh slot and decodes hex nibbles to active-low segments {a,b,c,d,e,f,g,dp}.
- Double-buffers display data so updates land only at frame boundaries, so there is no tearing.
- Sits between CPU debug/IO registers and the board's shared-cathode segment bus and per-digit anodes.

Parameters:
- N_DIGITS, 8, number of digits scanned (1..16).
- REFRESH_DIV, 100000, clock cycles per digit slot (>= GUARD+2).
- GUARD, 2, cycles at the start of each slot with all anodes off, for anti-ghosting (0 allowed).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  scan enable; low blanks the display.
- LOAD  in  1  one-cycle strobe that captures DATA/DP/BLANK into the pending buffer.
- DATA  in  4*N_DIGITS  hex nibbles; digit i = DATA[4i+3:4i]; digit 0 is rightmost.
- DP  in  N_DIGITS  decimal point per digit, 1 = lit.
- BLANK  in  N_DIGITS  per-digit blank mask, 1 = digit dark.
- SEG  out  8  active-low segments {a,b,c,d,e,f,g,dp}.
- AN  out  N_DIGITS  active-low digit enables, at most one low at a time.
- FRAME  out  1  one-cycle pulse when the scan wraps from digit N_DIGITS-1 to digit 0.

Behaviour:
Reset (asynchronous, RST_N=0):
- SEG=8'hFF, AN all ones, FRAME=0.
- Prescaler=0, digit index=0.
- Pending and active buffers cleared to DATA=0, DP=0, BLANK=all ones.
- Pending flag=0.

Prescaler and scan:
- Prescaler counts 0..REFRESH_DIV-1 while EN=1.
- tick = prescaler==REFRESH_DIV-1; on tick the prescaler returns to 0 and the index advances.
- Index wraps N_DIGITS-1 -> 0; FRAME=1 on that tick cycle only.

Buffering:
- LOAD=1 writes DATA/DP/BLANK into the pending buffer and sets pending.
- Repeated LOADs before a wrap: the last one wins.
- On the wrap tick, if pending, copy pending to active and clear pending.
- LOAD on the same cycle as a wrap tick: that cycle's inputs go straight into active, and pending is cleared.

Segment decode:
- Per nibble, before dp merge: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001101, 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000.
- SEG[0] = ~DP_active[index].

Output timing:
- SEG and AN are registered, one cycle after the index or prescaler state that selects them.
- AN[index]=0 only when all of these hold: EN=1, prescaler >= GUARD (as registered), BLANK_active[index]=0.
- Otherwise all AN bits are 1, and SEG=8'hFF whenever AN is all ones.

EN behaviour:
- EN=0: prescaler and index synchronously cleared; outputs go to SEG=FF and AN all ones next cycle; FRAME=0.
- Buffers and LOAD still operate, but no wrap occurs, so pending persists until scanning resumes and completes a frame.
- EN rising: scan restarts at digit 0, prescaler 0.

Reset mid-frame: asynchronous clear as above. Any pending data is lost.

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- Defined: a digit whose active nibble is 0 is additionally blanked when every more-significant digit is also 0 or BLANK.
  - Digit 0 is never suppressed.
  - A suppressed digit with DP lit still shows dp only: SEG=8'hFE, AN low.
- Not defined: zeros display normally; no extra logic is synthesised.

Test Plan (N_DIGITS=4, REFRESH_DIV=4, GUARD=1):
- Reset release, EN=1, no LOAD -> AN=4'b1111 and SEG=FF throughout, since reset BLANK is all ones; FRAME pulses every 16 cycles.
- LOAD with DATA=16'h12AF, DP=0, BLANK=0 mid-frame -> old (blank) data until the next FRAME. Then per slot: 1 cycle AN=1111, then 3 cycles AN=1110 with SEG=8'b01110001 (F), AN=1101 with SEG=8'b00010001 (A), AN=1011 with SEG=8'b00100101 (2), AN=0111 with SEG=8'b10011111 (1).
- Two LOADs before a wrap (16'h1111 then 16'h2222) -> frame shows 2222 only; LOAD coincident with the FRAME tick -> that value is shown from digit 0 of the new frame.
- DP=4'b0100, BLANK=4'b0010 -> digit 2 SEG[0]=0; digit 1 slot AN=1111 and SEG=FF.
- EN dropped mid-frame for 5 cycles -> next cycle SEG=FF and AN=1111; after EN returns, the scan restarts at digit 0 and the first FRAME comes 16 cycles later. RST_N pulsed mid-slot -> outputs reach their reset values without waiting for a clock.
- With SEG_SCAN_LEADING_ZERO_BLANK_EN, DATA=16'h0050, DP=4'b1000 -> digit 3 shows SEG=FE, digit 2 dark, digit 1 shows 5, digit 0 shows 0. Without the macro -> 0,0,5,0 with dp on digit 3.
